// File: rtl/mem_responder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_responder_pkg: shared state encoding and constants             |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package mem_responder_pkg;

  localparam int WORD_W = 16;

  localparam logic [WORD_W-1:0] GPU_ADDR_DEFAULT = 16'd20;
  localparam logic [WORD_W-1:0] ACC_ADDR_DEFAULT = 16'd21;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/mem_responder_ram.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_responder_ram: single-port RAM, synchronous read, no reset     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mem_responder_ram
  import mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WORD_W-1:0]     wdata,
  output logic [WORD_W-1:0]     rdata
);

  logic [WORD_W-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_responder: CPU-side request responder over on-chip RAM + MMIO  |
// | Optional macro MEM_ERR_EN adds out-of-range detection/respError.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int                ADDR_WIDTH = 12,
  parameter logic [WORD_W-1:0] GPU_ADDR   = GPU_ADDR_DEFAULT,
  parameter logic [WORD_W-1:0] ACC_ADDR   = ACC_ADDR_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic              reqWrite,
  input  logic [WORD_W-1:0] reqAddress,
  input  logic [WORD_W-1:0] reqData,
  output logic              respValid,
  input  logic              respReady,
  output logic [WORD_W-1:0] respData,
  input  logic [WORD_W-1:0] gpuData,
  input  logic [WORD_W-1:0] accessoryData
`ifdef MEM_ERR_EN
  ,
  output logic              respError
`endif
);

  state_e              state_q, state_d;
  logic                wr_q, wr_d;
  logic [WORD_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic [WORD_W-1:0]   resp_data_q, resp_data_d;
  logic                resp_err_q, resp_err_d;

  logic                is_gpu, is_acc, is_mmio, out_of_range;
  logic                ram_en, ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [WORD_W-1:0]   ram_rdata;

  assign is_gpu  = (addr_q == GPU_ADDR);
  assign is_acc  = (addr_q == ACC_ADDR);
  assign is_mmio = is_gpu | is_acc;

`ifdef MEM_ERR_EN
  assign out_of_range = (addr_q[WORD_W-1:ADDR_WIDTH] != '0) && !is_mmio;
`else
  assign out_of_range = 1'b0;
`endif

  // The RAM read is launched while still in IDLE so the word is ready during ACCESS.
  assign ram_we   = (state_q == ACCESS) && wr_q && !is_mmio && !out_of_range;
  assign ram_en   = ((state_q == IDLE) && reqValid) || ram_we;
  assign ram_addr = (state_q == IDLE) ? reqAddress[ADDR_WIDTH-1:0]
                                      : addr_q[ADDR_WIDTH-1:0];

  mem_responder_ram #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    case (state_q)
      IDLE: begin
        if (reqValid) begin
          wr_d    = reqWrite;
          addr_d  = reqAddress;
          wdata_d = reqData;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        resp_err_d = out_of_range;
        if (wr_q || out_of_range) begin
          resp_data_d = '0;
        end else if (is_gpu) begin
          resp_data_d = gpuData;
        end else if (is_acc) begin
          resp_data_d = accessoryData;
        end else begin
          resp_data_d = ram_rdata;
        end
        state_d = RESPOND;
      end
      RESPOND: begin
        if (respReady) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    reqReady  = (state_q == IDLE);
    respValid = (state_q == RESPOND);
    respData  = resp_data_q;
`ifdef MEM_ERR_EN
    respError = resp_err_q & (state_q == RESPOND);
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mem_responder: scoreboard-based self-checking bench             |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_mem_responder;

  logic        clk;
  logic        reset;
  logic        reqValid;
  logic        reqReady;
  logic        reqWrite;
  logic [15:0] reqAddress;
  logic [15:0] reqData;
  logic        respValid;
  logic        respReady;
  logic [15:0] respData;
  logic [15:0] gpuData;
  logic [15:0] accessoryData;
  logic        respError;

  typedef struct packed {
    logic [15:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  mem_responder #(
    .ADDR_WIDTH (12),
    .GPU_ADDR   (16'd20),
    .ACC_ADDR   (16'd21)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .reqValid      (reqValid),
    .reqReady      (reqReady),
    .reqWrite      (reqWrite),
    .reqAddress    (reqAddress),
    .reqData       (reqData),
    .respValid     (respValid),
    .respReady     (respReady),
    .respData      (respData),
    .gpuData       (gpuData),
    .accessoryData (accessoryData)
`ifdef MEM_ERR_EN
    ,
    .respError     (respError)
`endif
  );

`ifndef MEM_ERR_EN
  assign respError = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one request, wait for its response and check it against the scoreboard.
  task automatic issue(input logic w, input logic [15:0] a, input logic [15:0] d,
                       input logic [15:0] exp_d, input logic exp_e, input string name);
    int   lat;
    int   guard;
    exp_t e;
    guard = 0;
    while (!reqReady && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    reqValid   = 1'b1;
    reqWrite   = w;
    reqAddress = a;
    reqData    = d;
    @(posedge clk); #1;
    sb.push_back('{data: exp_d, err: exp_e});
    reqValid   = 1'b0;
    reqWrite   = 1'($urandom);
    reqAddress = 16'($urandom);
    reqData    = 16'($urandom);
    lat = 1;
    while (!respValid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    e = sb.pop_front();
    total++;
    if (lat != 2) begin
      bad++;
      $display("FAIL %s latency: got %0d cycles, want 2", name, lat);
    end
    total++;
    if (respData !== e.data) begin
      bad++;
      $display("FAIL %s data: got %h, want %h", name, respData, e.data);
    end
    total++;
    if (respError !== e.err) begin
      bad++;
      $display("FAIL %s error: got %b, want %b", name, respError, e.err);
    end
  endtask

  task automatic accept(input string name);
    respReady = 1'b1;
    @(posedge clk); #1;
    respReady = 1'b0;
    total++;
    if (reqReady !== 1'b1 || respValid !== 1'b0) begin
      bad++;
      $display("FAIL %s accept: reqReady=%b respValid=%b, want 1/0", name, reqReady, respValid);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (reqReady !== 1'b1 || respValid !== 1'b0 || respData !== 16'h0 || respError !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: ready=%b valid=%b data=%h err=%b, want 1 0 0000 0",
               reqReady, respValid, respData, respError);
    end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read;
    issue(1'b1, 16'd1, 16'h003A, 16'h0000, 1'b0, "wr1");
    accept("wr1");
    issue(1'b0, 16'd1, 16'h0000, 16'h003A, 1'b0, "rd1");
    accept("rd1");
    total++;
    if (respData !== 16'h003A) begin
      bad++;
      $display("FAIL hold_after_accept: got %h, want 003a", respData);
    end
  endtask

  task automatic test_alias;
    issue(1'b1, 16'd512, 16'h0010, 16'h0000, 1'b0, "wr512");
    accept("wr512");
    issue(1'b1, 16'd1, 16'h00A0, 16'h0000, 1'b0, "wr1b");
    accept("wr1b");
    issue(1'b0, 16'd512, 16'h0000, 16'h0010, 1'b0, "rd512");
    accept("rd512");
    issue(1'b0, 16'd1, 16'h0000, 16'h00A0, 1'b0, "rd1b");
    accept("rd1b");
  endtask

  task automatic test_mmio;
    gpuData       = 16'h0042;
    accessoryData = 16'h0037;
    issue(1'b0, 16'd20, 16'h0000, 16'h0042, 1'b0, "rd_gpu");
    accept("rd_gpu");
    issue(1'b0, 16'd21, 16'h0000, 16'h0037, 1'b0, "rd_acc");
    accept("rd_acc");
    issue(1'b1, 16'd20, 16'hFFFF, 16'h0000, 1'b0, "wr_gpu");
    accept("wr_gpu");
    issue(1'b0, 16'd20, 16'h0000, 16'h0042, 1'b0, "rd_gpu2");
    accept("rd_gpu2");
    gpuData = 16'h1357;
    issue(1'b0, 16'd20, 16'h0000, 16'h1357, 1'b0, "rd_gpu_live");
    accept("rd_gpu_live");
  endtask

  task automatic test_backpressure;
    issue(1'b0, 16'd1, 16'h0000, 16'h00A0, 1'b0, "bp");
    reqValid   = 1'b1;
    reqWrite   = 1'b1;
    reqAddress = 16'd1;
    reqData    = 16'hDEAD;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (respValid !== 1'b1 || respData !== 16'h00A0 || reqReady !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold[%0d]: valid=%b data=%h ready=%b, want 1 00a0 0",
                 i, respValid, respData, reqReady);
      end
    end
    reqValid = 1'b0;
    accept("bp");
    issue(1'b0, 16'd1, 16'h0000, 16'h00A0, 1'b0, "bp_after");
    accept("bp_after");
  endtask

  task automatic test_reset_mid;
    reqValid   = 1'b1;
    reqWrite   = 1'b1;
    reqAddress = 16'd512;
    reqData    = 16'h0020;
    @(posedge clk); #1;
    reqValid = 1'b0;
    reset    = 1'b0;
    #1;
    total++;
    if (reqReady !== 1'b1 || respValid !== 1'b0 || respData !== 16'h0) begin
      bad++;
      $display("FAIL reset_mid: ready=%b valid=%b data=%h, want 1 0 0000",
               reqReady, respValid, respData);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    issue(1'b0, 16'd512, 16'h0000, 16'h0010, 1'b0, "rd512_after_reset");
    accept("rd512_after_reset");
  endtask

  task automatic test_range;
    issue(1'b1, 16'd5, 16'h1234, 16'h0000, 1'b0, "wr5");
    accept("wr5");
`ifdef MEM_ERR_EN
    issue(1'b0, 16'h1005, 16'h0000, 16'h0000, 1'b1, "rd_oor");
    accept("rd_oor");
    issue(1'b1, 16'h1005, 16'hBEEF, 16'h0000, 1'b1, "wr_oor");
    accept("wr_oor");
    issue(1'b0, 16'd5, 16'h0000, 16'h1234, 1'b0, "rd5_after_oor");
    accept("rd5_after_oor");
`else
    issue(1'b0, 16'h1005, 16'h0000, 16'h1234, 1'b0, "rd_wrap");
    accept("rd_wrap");
`endif
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 16'(100 + i), 16'(16'hA500 + i), 16'h0000, 1'b0, "b2b_wr");
      accept("b2b_wr");
    end
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, 16'(100 + i), 16'h0000, 16'(16'hA500 + i), 1'b0, "b2b_rd");
      accept("b2b_rd");
    end
  endtask

  initial begin
    reqValid      = 1'b0;
    reqWrite      = 1'b0;
    reqAddress    = 16'h0;
    reqData       = 16'h0;
    respReady     = 1'b0;
    gpuData       = 16'h0;
    accessoryData = 16'h0;
    test_reset();
    test_write_read();
    test_alias();
    test_mmio();
    test_backpressure();
    test_reset_mid();
    test_range();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Responder end of the CPU-side memory request interface. Accepts single read/write requests from an initiator (CPU core, test harness) and services them from on-chip RAM.
- Maps two read-only I/O words (GPU data, accessory data) into the address space.
- Returns one response per request over a valid/ready handshake.
- Sits between the CPU/test initiator and the block RAM.

Parameters:
- ADDR_WIDTH, 12: RAM depth is 2**ADDR_WIDTH words of 16 bits.
- GPU_ADDR, 16'd20: address that returns gpuData.
- ACC_ADDR, 16'd21: address that returns accessoryData.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- reqValid  in  1  initiator has a request.
- reqReady  out  1  responder can accept a request.
- reqWrite  in  1  1 = write, 0 = read.
- reqAddress  in  16  word address.
- reqData  in  16  write data.
- respValid  out  1  response available.
- respReady  in  1  initiator accepts the response.
- respData  out  16  read data; 0 for write responses.
- gpuData  in  16  live value returned at GPU_ADDR.
- accessoryData  in  16  live value returned at ACC_ADDR.
- respError  out  1  only with MEM_ERR_EN; see Optional Feature.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; reqReady=1; respValid=0; respData=0; respError=0.
  - RAM contents are not cleared.
  - Reset mid-transaction drops the pending request and response; a write not yet committed is not performed.
- States:
  - IDLE: reqReady=1. When reqValid=1, latch reqWrite, reqAddress and reqData, then go to ACCESS.
  - ACCESS: reqReady=0.
    - Write to a RAM address: RAM[reqAddress[ADDR_WIDTH-1:0]] is written at the end of this cycle.
    - Read: the RAM word is read synchronously.
    - Next state is RESPOND.
  - RESPOND: respValid=1 and respData stable. When respReady=1, go to IDLE; otherwise hold.
- Latency and throughput:
  - Request handshake in cycle N gives respValid=1 from cycle N+2.
  - A response accepted in cycle M allows the next request in cycle M+1.
  - Peak throughput is 1 request per 3 cycles.
- Read data source, in priority order:
  - addr==GPU_ADDR: gpuData, sampled in the ACCESS cycle.
  - addr==ACC_ADDR: accessoryData, sampled in the ACCESS cycle.
  - Otherwise: the RAM word.
- Writes to GPU_ADDR or ACC_ADDR: discarded; RAM is unchanged; a response is still returned.
- Address decode: without MEM_ERR_EN, addresses at or above 2**ADDR_WIDTH wrap by truncating to ADDR_WIDTH bits.
- Ordering: a read after a write to the same address returns the new value.
- Request inputs are ignored outside IDLE.
- respData holds its value after the handshake until the next response is loaded.

Optional Feature:
- Macro: MEM_ERR_EN.
- Defined:
  - The respError port exists.
  - Any address with nonzero bits above ADDR_WIDTH-1 (excluding GPU_ADDR and ACC_ADDR) is out of range.
  - Out-of-range reads return respData=0. Out-of-range writes are dropped.
  - respError=1 is asserted together with respValid for that response, and 0 for all other responses.
- Undefined: no respError port; addresses wrap as above.

Decomposition:
- Shared package:
  - state encoding: IDLE=2'd0, ACCESS=2'd1, RESPOND=2'd2.
  - default GPU_ADDR and ACC_ADDR constants.
  - the 16-bit word width constant.
- One sub-module: mem_responder_ram, a single-port synchronous-read RAM parameterised by ADDR_WIDTH.
- Decode, state machine and response registers stay in mem_responder.

Test Plan:
- Write then read:
  - Write 16'h003A to address 1, then read address 1 -> respData=16'h003A.
  - The read respValid rises 2 cycles after the request handshake.
- Address alias: with ADDR_WIDTH=12, write 16'h0010 to 512 and 16'h00A0 to 1; read both -> 16'h0010 and 16'h00A0.
- MMIO:
  - gpuData=16'h0042, accessoryData=16'h0037. Read 20 -> 16'h0042; read 21 -> 16'h0037.
  - Write 16'hFFFF to 20, read 20 again -> still 16'h0042.
- Backpressure:
  - Hold respReady=0 for 5 cycles -> respValid stays 1, respData stable, reqReady stays 0.
  - On release, reqReady=1 in the following cycle.
- Reset mid-operation: assert reset during ACCESS of a write of 16'h0020 to 512 -> outputs clear immediately; a later read of 512 returns the prior value.
- MEM_ERR_EN: read address 16'h1005 -> respData=0 and respError=1. Without the macro, the same read returns the contents of address 5.
